// File: rtl/regfile_exec_unit.sv
// Execute stage behind the 8x16 register file: latches operands on start, computes an ALU
// result in one cycle or a shift-add multiply in 16, and pulses the write-back port.
// Optional multiply datapath: define REGFILE_EXEC_MUL_EN.
module regfile_exec_unit #(
  parameter int WIDTH    = 16,
  parameter int AW       = 3,
  parameter int MUL_ITER = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    addre_dst,
  input  logic [WIDTH-1:0] QA,
  input  logic [WIDTH-1:0] QB,
  output logic [WIDTH-1:0] D,
  output logic [AW-1:0]    addre_wr,
  output logic             we,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry,
  output logic             ill_op
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_e;

`ifdef REGFILE_EXEC_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WB} state_e;
`else
  typedef enum logic {ST_IDLE, ST_WB} state_e;
`endif

  if (MUL_ITER != WIDTH) begin : g_cfg_check
    $error("regfile_exec_unit: MUL_ITER must equal WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic [AW-1:0]    dst_q;
  logic             accept;

  logic [WIDTH-1:0] d_q;
  logic [AW-1:0]    wr_q;
  logic             we_q, done_q, zero_q, carry_q;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   sum_w, diff_w;

  assign accept = (state_q == ST_IDLE) && start;

`ifdef REGFILE_EXEC_MUL_EN
  localparam int CW = $clog2(MUL_ITER);

  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
`endif

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef REGFILE_EXEC_MUL_EN
          state_d = (op_e'(op) == OP_MUL) ? ST_MUL : ST_WB;
`else
          state_d = ST_WB;
`endif
        end
      end
`ifdef REGFILE_EXEC_MUL_EN
      ST_MUL:  if (cnt_q == CW'(MUL_ITER - 1)) state_d = ST_WB;
`endif
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= QA;
        b_q   <= QB;
        op_q  <= op_e'(op);
        dst_q <= addre_dst;
      end
    end
  end

`ifdef REGFILE_EXEC_MUL_EN
  // Bit 0 of the multiplier is consumed on the start edge, the other 15 in ST_MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept && (op_e'(op) == OP_MUL)) begin
      acc_q    <= QB[0] ? {{WIDTH{1'b0}}, QA} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, QA, 1'b0};
      mplier_q <= QB >> 1;
      cnt_q    <= CW'(1);
    end else if (state_q == ST_MUL) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`endif

  always_comb begin
    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    diff_w = {1'b0, a_q} - {1'b0, b_q};
    res    = '0;
    res_c  = 1'b0;
    case (op_q)
      OP_ADD: begin res = sum_w[WIDTH-1:0];  res_c = sum_w[WIDTH];  end
      OP_SUB: begin res = diff_w[WIDTH-1:0]; res_c = diff_w[WIDTH]; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_SHL: res = a_q << b_q[3:0];
      OP_SHR: res = a_q >> b_q[3:0];
`ifdef REGFILE_EXEC_MUL_EN
      OP_MUL: begin res = acc_q[WIDTH-1:0]; res_c = |acc_q[2*WIDTH-1:WIDTH]; end
`endif
      default: begin res = '0; res_c = 1'b0; end
    endcase
  end

`ifndef REGFILE_EXEC_MUL_EN
  logic ill_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`ifndef REGFILE_EXEC_MUL_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
`ifndef REGFILE_EXEC_MUL_EN
      ill_q  <= 1'b0;
`endif
      if (state_q == ST_WB) begin
        done_q <= 1'b1;
`ifndef REGFILE_EXEC_MUL_EN
        // A multiply with the datapath compiled out completes without touching the result regs.
        if (op_q == OP_MUL) ill_q <= 1'b1;
        else begin
`else
        begin
`endif
          we_q    <= 1'b1;
          d_q     <= res;
          wr_q    <= dst_q;
          zero_q  <= (res == '0);
          carry_q <= res_c;
        end
      end
    end
  end

  assign D        = d_q;
  assign addre_wr = wr_q;
  assign we       = we_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign busy     = (state_q != ST_IDLE);
`ifdef REGFILE_EXEC_MUL_EN
  assign ill_op   = 1'b0;
`else
  assign ill_op   = ill_q;
`endif

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Directed self-checking bench for regfile_exec_unit; observed outputs are packed as
// {D, addre_wr, we, done, busy, zero, carry, ill_op}.
module tb_regfile_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  addre_dst;
  logic [15:0] QA, QB;
  logic [15:0] D;
  logic [2:0]  addre_wr;
  logic        we, busy, done, zero, carry, ill_op;

  int checks = 0;
  int errors = 0;

  logic [24:0] obs;
  assign obs = {D, addre_wr, we, done, busy, zero, carry, ill_op};

  always #5 clk = ~clk;

  regfile_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .addre_dst (addre_dst),
    .QA        (QA),
    .QB        (QB),
    .D         (D),
    .addre_wr  (addre_wr),
    .we        (we),
    .busy      (busy),
    .done      (done),
    .zero      (zero),
    .carry     (carry),
    .ill_op    (ill_op)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dst;
    logic [15:0] d;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl [9];

  // Drives a one-cycle start; returns 1 time unit after the accepting edge (edge N).
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dst);
    @(negedge clk);
    start = 1'b1; op = o; QA = a; QB = b; addre_dst = dst;
    @(posedge clk);
    #1;
    start = 1'b0;
    QA = 16'($urandom);
    QB = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL reset_state got %h expected %h", obs, 25'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({we, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_release got we,busy=%b expected 00", {we, busy});
    end
  endtask

  task automatic test_add();
    issue(3'b000, 16'd10, 16'd8, 3'd3);
    checks++;
    if ({we, busy} !== 2'b01) begin
      errors++; $display("FAIL add_busy got we,busy=%b expected 01", {we, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd18, 3'd3, 6'b110000}) begin
      errors++; $display("FAIL add_result got %h expected %h", obs, {16'd18, 3'd3, 6'b110000});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd18, 3'd3, 6'b000000}) begin
      errors++; $display("FAIL add_hold got %h expected %h", obs, {16'd18, 3'd3, 6'b000000});
    end
  endtask

  task automatic test_sub();
    issue(3'b001, 16'd8, 16'd10, 3'd1);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'hFFFE, 3'd1, 6'b110010}) begin
      errors++; $display("FAIL sub_borrow got %h expected %h", obs, {16'hFFFE, 3'd1, 6'b110010});
    end
    issue(3'b001, 16'd5, 16'd5, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'h0000, 3'd0, 6'b110100}) begin
      errors++; $display("FAIL sub_zero got %h expected %h", obs, {16'h0000, 3'd0, 6'b110100});
    end
  endtask

  task automatic test_alu_ops();
    tbl[0] = '{3'b010, 16'hF0F0, 16'h0FF0, 3'd1, 16'h00F0, 1'b0, 1'b0};
    tbl[1] = '{3'b011, 16'hF0F0, 16'h0FF0, 3'd2, 16'hFFF0, 1'b0, 1'b0};
    tbl[2] = '{3'b100, 16'hAAAA, 16'hAAAA, 3'd3, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{3'b101, 16'h8001, 16'h0004, 3'd4, 16'h0010, 1'b0, 1'b0};
    tbl[4] = '{3'b110, 16'h8001, 16'hFFF4, 3'd5, 16'h0800, 1'b0, 1'b0};
    tbl[5] = '{3'b101, 16'h1234, 16'h0010, 3'd6, 16'h1234, 1'b0, 1'b0};
    tbl[6] = '{3'b110, 16'h8000, 16'h000F, 3'd7, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{3'b000, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1};
    tbl[8] = '{3'b000, 16'h7FFF, 16'h7FFF, 3'd7, 16'hFFFE, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst);
      @(posedge clk); #1;
      checks++;
      if (obs !== {tbl[i].d, tbl[i].dst, 3'b110, tbl[i].z, tbl[i].c, 1'b0}) begin
        errors++;
        $display("FAIL alu_op[%0d] got %h expected %h", i, obs,
                 {tbl[i].d, tbl[i].dst, 3'b110, tbl[i].z, tbl[i].c, 1'b0});
      end
    end
  endtask

  // start held high: ignored while busy, accepted again in the done cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'b000; QA = 16'd7; QB = 16'd1; addre_dst = 3'd6;
    @(posedge clk); #1;
    QA = 16'd20;
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd8, 3'd6, 6'b110000}) begin
      errors++; $display("FAIL b2b_first got %h expected %h", obs, {16'd8, 3'd6, 6'b110000});
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({we, busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_accept got we,busy=%b expected 01", {we, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd21, 3'd6, 6'b110000}) begin
      errors++; $display("FAIL b2b_second got %h expected %h", obs, {16'd21, 3'd6, 6'b110000});
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    issue(3'b000, 16'd4, 16'd4, 3'd5);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL async_reset got %h expected %h", obs, 25'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (we !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_no_we got %0d bad cycles expected 0", bad);
    end
    issue(3'b000, 16'd1, 16'd1, 3'd0);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd2, 3'd0, 6'b110000}) begin
      errors++; $display("FAIL reset_then_add got %h expected %h", obs, {16'd2, 3'd0, 6'b110000});
    end
  endtask

`ifdef REGFILE_EXEC_MUL_EN
  task automatic test_mul();
    int bad;
    int extra;
    bad = 0;
    issue(3'b111, 16'd300, 16'd300, 3'd2);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy !== 1'b1 || we !== 1'b0) bad++;
      if (k == 4) begin
        start = 1'b1; op = 3'b000; QA = 16'd1; QB = 16'd1; addre_dst = 3'd5;
      end
      if (k == 5) start = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mul_busy got %0d bad cycles expected 0", bad);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'h5F90, 3'd2, 6'b110010}) begin
      errors++; $display("FAIL mul_result got %h expected %h", obs, {16'h5F90, 3'd2, 6'b110010});
    end
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (we !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0 || obs !== {16'h5F90, 3'd2, 6'b000010}) begin
      errors++; $display("FAIL mul_single_we got extra=%0d obs=%h expected 0 %h", extra, obs,
                         {16'h5F90, 3'd2, 6'b000010});
    end
  endtask

  task automatic test_mul_abort();
    int pulses;
    issue(3'b111, 16'd3, 16'd5, 3'd2);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++; $display("FAIL mul_abort_reset got %h expected %h", obs, 25'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (we !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL mul_abort_no_we got %0d pulses expected 0", pulses);
    end
    issue(3'b000, 16'd1, 16'd1, 3'd3);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd2, 3'd3, 6'b110000}) begin
      errors++; $display("FAIL mul_abort_add got %h expected %h", obs, {16'd2, 3'd3, 6'b110000});
    end
  endtask
`else
  task automatic test_ill_op();
    issue(3'b000, 16'd10, 16'd8, 3'd3);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd18, 3'd3, 6'b110000}) begin
      errors++; $display("FAIL ill_setup got %h expected %h", obs, {16'd18, 3'd3, 6'b110000});
    end
    issue(3'b111, 16'd300, 16'd300, 3'd2);
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd18, 3'd3, 6'b010001}) begin
      errors++; $display("FAIL ill_pulse got %h expected %h", obs, {16'd18, 3'd3, 6'b010001});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {16'd18, 3'd3, 6'b000000}) begin
      errors++; $display("FAIL ill_clear got %h expected %h", obs, {16'd18, 3'd3, 6'b000000});
    end
  endtask
`endif

  initial begin
    start     = 1'b0;
    op        = 3'b000;
    addre_dst = 3'd0;
    QA        = 16'd0;
    QB        = 16'd0;
    test_reset();
    test_add();
    test_sub();
    test_alu_ops();
    test_back_to_back();
    test_reset_mid_run();
`ifdef REGFILE_EXEC_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_ill_op();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
